// File: rtl/issue_scoreboard.sv
// issue_scoreboard: single-entry decode register with RV32I field decode,
// register file with writeback bypass, and a per-register pending-write
// scoreboard that holds an instruction until its operands and destination
// are free.
//
// Ports
//   clk, nrst                      clock, synchronous active-low reset
//   in_valid/in_ready/in_instr     fetch handshake and raw RV32I instruction
//   flush                          discard the held instruction
//   wb_en/wb_addr/wb_data          register writeback port
//   out_valid/out_ready            issue handshake to execute
//   out_op_a/out_op_b              rs1/rs2 values after bypass
//   out_imm/out_b_sel              immediate and operand-B select
//   out_rd/out_rd_we/out_instr     destination, write flag, raw instruction
module issue_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [XLEN-1:0] out_imm,
  output logic            out_b_sel,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we,
  output logic [31:0]     out_instr
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic                d_valid;
  logic [31:0]         d_instr;
  logic [XLEN-1:0]     regs [NREG];
  logic [NREG-1:0]     pending;
  logic [NREG-1:0]     pending_nxt;
  logic [NREG-1:0]     pend_eff;
  logic [NREG-1:0]     wb_mask;
  logic [NREG-1:0]     set_mask;

  logic [6:0]          opcode;
  logic [AW-1:0]       rs1;
  logic [AW-1:0]       rs2;
  logic [AW-1:0]       rd;
  logic signed [31:0]  imm32;
  logic                b_sel;
  logic                rd_we_raw;
  logic                rd_we;
  logic                uses_rs1;
  logic                uses_rs2;
  logic                hazard;
  logic                fire;
  logic                accept;

  // Field extraction from the held instruction
  assign opcode = d_instr[6:0];
  assign rs1    = d_instr[15 +: AW];
  assign rs2    = d_instr[20 +: AW];
  assign rd     = d_instr[7 +: AW];

  always_comb begin
    imm32     = '0;
    b_sel     = 1'b0;
    rd_we_raw = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (opcode)
      OPC_OP: begin
        rd_we_raw = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        imm32     = {{20{d_instr[31]}}, d_instr[31:20]};
        b_sel     = 1'b1;
        rd_we_raw = 1'b1;
        uses_rs1  = 1'b1;
      end
      OPC_STORE: begin
        imm32    = {{20{d_instr[31]}}, d_instr[31:25], d_instr[11:7]};
        b_sel    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm32    = {{19{d_instr[31]}}, d_instr[31], d_instr[7],
                    d_instr[30:25], d_instr[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32     = {d_instr[31:12], 12'b0};
        b_sel     = 1'b1;
        rd_we_raw = 1'b1;
      end
      OPC_JAL: begin
        imm32     = {{11{d_instr[31]}}, d_instr[31], d_instr[19:12],
                     d_instr[20], d_instr[30:21], 1'b0};
        b_sel     = 1'b1;
        rd_we_raw = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_we = rd_we_raw & (rd != '0);

  // A writeback landing this cycle satisfies RAW readers, but an
  // outstanding destination (WAW) still stalls until the bit is gone.
  assign wb_mask  = wb_en ? (NREG'(1) << wb_addr) : '0;
  assign pend_eff = pending & ~wb_mask;
  assign hazard   = (uses_rs1 & pend_eff[rs1]) |
                    (uses_rs2 & pend_eff[rs2]) |
                    (rd_we & pending[rd]);

  assign out_valid = d_valid & ~hazard & ~flush;
  assign fire      = out_valid & out_ready;
  assign in_ready  = (~d_valid | fire) & ~flush;
  assign accept    = in_valid & in_ready;

  // Set after clear so a same-cycle issue to rd wins over a stale writeback
  assign set_mask    = (fire & rd_we) ? (NREG'(1) << rd) : '0;
  assign pending_nxt = ((pending & ~wb_mask) | set_mask) & ~NREG'(1);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      d_valid <= 1'b0;
      d_instr <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (flush) begin
        d_valid <= 1'b0;
      end else if (accept) begin
        d_valid <= 1'b1;
        d_instr <= in_instr;
      end else if (fire) begin
        d_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Bypass keeps operands stable across the writeback edge while stalled
  always_comb begin
    out_op_a = regs[rs1];
    out_op_b = regs[rs2];
    if (wb_en && (wb_addr == rs1) && (rs1 != '0)) out_op_a = wb_data;
    if (wb_en && (wb_addr == rs2) && (rs2 != '0)) out_op_b = wb_data;
  end

  assign out_imm   = XLEN'(imm32);
  assign out_b_sel = b_sel;
  assign out_rd    = rd;
  assign out_rd_we = rd_we;
  assign out_instr = d_instr;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  localparam logic [6:0] K_OP     = 7'b0110011;
  localparam logic [6:0] K_OPIMM  = 7'b0010011;
  localparam logic [6:0] K_LOAD   = 7'b0000011;
  localparam logic [6:0] K_STORE  = 7'b0100011;
  localparam logic [6:0] K_BRANCH = 7'b1100011;
  localparam logic [6:0] K_LUI    = 7'b0110111;
  localparam logic [6:0] K_AUIPC  = 7'b0010111;
  localparam logic [6:0] K_JAL    = 7'b1101111;
  localparam logic [6:0] K_JALR   = 7'b1100111;
  localparam logic [6:0] K_UNK    = 7'b0001111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic        out_b_sel, out_rd_we;
  logic [31:0] in_instr, wb_data, out_op_a, out_op_b, out_imm, out_instr;
  logic [4:0]  wb_addr, out_rd;

  logic        in_valid64, in_ready64, flush64, wb_en64, out_valid64, out_ready64;
  logic        b_sel64, rd_we64;
  logic [31:0] in_instr64, instr64;
  logic [3:0]  wb_addr64, rd64;
  logic [63:0] wb_data64, op_a64, op_b64, imm64;

  int checks = 0;
  int errors = 0;

  issue_scoreboard #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_b_sel(out_b_sel), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_instr(out_instr)
  );

  issue_scoreboard #(.XLEN(64), .NREG(16)) dut64 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid64), .in_instr(in_instr64),
    .in_ready(in_ready64), .flush(flush64), .wb_en(wb_en64), .wb_addr(wb_addr64),
    .wb_data(wb_data64), .out_valid(out_valid64), .out_ready(out_ready64),
    .out_op_a(op_a64), .out_op_b(op_b64), .out_imm(imm64),
    .out_b_sel(b_sel64), .out_rd(rd64), .out_rd_we(rd_we64),
    .out_instr(instr64)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, K_OPIMM};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, K_OP};
  endfunction

  // Reference immediate, built arithmetically from the ISA bit layout
  function automatic int ref_imm(input logic [31:0] ins);
    int s;
    int sgn;
    s = ins;
    sgn = s >>> 31;
    if (ins[6:0] inside {K_OPIMM, K_LOAD, K_JALR}) return s >>> 20;
    if (ins[6:0] == K_STORE) return (s >>> 25) * 32 + int'(ins[11:7]);
    if (ins[6:0] == K_BRANCH)
      return sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    if (ins[6:0] inside {K_LUI, K_AUIPC}) return int'(ins & 32'hFFFFF000);
    if (ins[6:0] == K_JAL)
      return sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    return 0;
  endfunction

  function automatic bit ref_bsel(input logic [6:0] op);
    return op inside {K_OPIMM, K_LOAD, K_STORE, K_JALR, K_LUI, K_AUIPC, K_JAL};
  endfunction

  function automatic bit ref_rdwe(input logic [31:0] ins);
    return (ins[6:0] inside {K_OP, K_OPIMM, K_LOAD, K_LUI, K_AUIPC, K_JAL, K_JALR}) && (ins[11:7] != 0);
  endfunction

  function automatic bit ref_u1(input logic [6:0] op);
    return op inside {K_OP, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_JALR};
  endfunction

  function automatic bit ref_u2(input logic [6:0] op);
    return op inside {K_OP, K_STORE, K_BRANCH};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{K_OP, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_LUI, K_AUIPC, K_JAL, K_JALR, K_UNK};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(9)];
    r[11:7]  = 5'($urandom_range(7));
    r[19:15] = 5'($urandom_range(7));
    r[24:20] = 5'($urandom_range(7));
    return r;
  endfunction

  task automatic idle();
    in_valid = 1'b0; in_instr = '0; flush = 1'b0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    cyc(); cyc();
    nrst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    // Park an instruction in D, then reset on top of it with a writeback
    in_valid = 1'b1; in_instr = addi(5'd1, 5'd0, 12'd1); out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    nrst = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
    cyc();
    nrst = 1'b1; wb_en = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_stall: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    in_valid = 1'b1; in_instr = addi(5'd0, 5'd5, 12'd0); out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h0 || out_rd_we !== 1'b0) begin
      errors++; $display("FAIL reset_wb_ignored: valid=%b op_a=%h rd_we=%b want 1/0/0", out_valid, out_op_a, out_rd_we);
    end
    cyc();
    idle();
  endtask

  task automatic test_issue_raw();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
    cyc();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = addi(5'd6, 5'd5, 12'd3); out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL addi_pre: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    cyc();
    in_instr = add(5'd7, 5'd6, 5'd6);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h11 || out_imm !== 32'd3 || out_b_sel !== 1'b1 ||
        out_rd !== 5'd6 || out_rd_we !== 1'b1) begin
      errors++; $display("FAIL addi_issue: v=%b a=%h imm=%h bsel=%b rd=%0d we=%b want 1/11/3/1/6/1",
                         out_valid, out_op_a, out_imm, out_b_sel, out_rd, out_rd_we);
    end
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL raw_stall[%0d]: out_valid=%b want 0", k, out_valid);
      end
      cyc();
    end
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h14;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h14 || out_op_b !== 32'h14) begin
      errors++; $display("FAIL raw_bypass: v=%b a=%h b=%h want 1/14/14", out_valid, out_op_a, out_op_b);
    end
    cyc();
    idle();
  endtask

  task automatic test_hold();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h99;
    in_valid = 1'b1; in_instr = addi(5'd8, 5'd0, 12'd5); out_ready = 1'b0;
    cyc();
    wb_en = 1'b0;
    in_instr = addi(5'd9, 5'd0, 12'd6);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_instr !== addi(5'd8, 5'd0, 12'd5) ||
          out_imm !== 32'd5 || out_rd !== 5'd8) begin
        errors++; $display("FAIL hold[%0d]: v=%b rdy=%b instr=%h imm=%h rd=%0d", k,
                           out_valid, in_ready, out_instr, out_imm, out_rd);
      end
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_single_fire: out_valid=%b want 0", out_valid);
    end
    // x8 must be pending from exactly that one fire
    in_valid = 1'b1; in_instr = add(5'd10, 5'd8, 5'd0);
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_pending_set: out_valid=%b want 0", out_valid);
    end
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h5;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h5) begin
      errors++; $display("FAIL hold_release: v=%b a=%h want 1/5", out_valid, out_op_a);
    end
    cyc();
    idle();
  endtask

  task automatic test_lui_beq();
    in_valid = 1'b1; in_instr = {20'h12345, 5'd0, K_LUI}; out_ready = 1'b1;
    cyc();
    in_instr = {1'b1, 6'h3F, 5'd2, 5'd1, 3'b000, 4'hC, 1'b1, K_BRANCH};
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_rd_we !== 1'b0 || out_imm !== 32'h12345000 || out_b_sel !== 1'b1) begin
      errors++; $display("FAIL lui_x0: v=%b we=%b imm=%h bsel=%b want 1/0/12345000/1",
                         out_valid, out_rd_we, out_imm, out_b_sel);
    end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFF8 || out_b_sel !== 1'b0 || out_rd_we !== 1'b0) begin
      errors++; $display("FAIL beq: v=%b imm=%h bsel=%b we=%b want 1/fffffff8/0/0",
                         out_valid, out_imm, out_b_sel, out_rd_we);
    end
    cyc();
    idle();
  endtask

  task automatic test_flush();
    // x10 is pending from the earlier ADD x10
    in_valid = 1'b1; in_instr = add(5'd12, 5'd10, 5'd0); out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_prestall: out_valid=%b want 0", out_valid);
    end
    cyc();
    flush = 1'b1; in_valid = 1'b1; in_instr = addi(5'd15, 5'd0, 12'd1);
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hAB;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: v=%b rdy=%b want 0/0", out_valid, in_ready);
    end
    cyc();
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_after: v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    in_valid = 1'b1; in_instr = add(5'd13, 5'd12, 5'd10);
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_op_b !== 32'hAB) begin
      errors++; $display("FAIL flush_next: v=%b b=%h want 1/ab", out_valid, out_op_b);
    end
    cyc();
    idle();
  endtask

  task automatic test_waw_set_wins();
    in_valid = 1'b1; in_instr = addi(5'd3, 5'd0, 12'd1); out_ready = 1'b1;
    cyc();
    in_instr = addi(5'd3, 5'd0, 12'd2);
    cyc();
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL waw_stall: out_valid=%b want 0", out_valid);
    end
    cyc();
    wb_data = 32'h44;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'd2) begin
      errors++; $display("FAIL waw_release: v=%b imm=%h want 1/2", out_valid, out_imm);
    end
    cyc();
    wb_en = 1'b0;
    in_valid = 1'b1; in_instr = add(5'd4, 5'd3, 5'd0);
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL set_wins: out_valid=%b want 0", out_valid);
    end
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h55) begin
      errors++; $display("FAIL set_wins_release: v=%b a=%h want 1/55", out_valid, out_op_a);
    end
    cyc();
    idle();
  endtask

  task automatic test_random();
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_dv;
    logic [31:0] m_di;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ea, eb, eimm;
    bit          hz, ev, er, efire, eacc;
    int          plist [$];

    nrst = 1'b0;
    cyc(); cyc();
    nrst = 1'b1;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
    m_dv = 1'b0; m_di = '0;

    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(2) != 0);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      wb_en     = ($urandom_range(2) == 0);
      plist.delete();
      for (int r = 1; r < 8; r++) if (m_pend[r]) plist.push_back(r);
      if (plist.size() != 0 && $urandom_range(3) != 0)
        wb_addr = 5'(plist[$urandom_range(plist.size() - 1)]);
      else
        wb_addr = 5'($urandom_range(7));
      wb_data = $urandom;
      #1;

      rs1 = m_di[19:15]; rs2 = m_di[24:20]; rd = m_di[11:7];
      hz = (ref_u1(m_di[6:0]) && m_pend[rs1] && !(wb_en && wb_addr == rs1)) ||
           (ref_u2(m_di[6:0]) && m_pend[rs2] && !(wb_en && wb_addr == rs2)) ||
           (ref_rdwe(m_di) && m_pend[rd]);
      ev    = m_dv && !hz && !flush;
      efire = ev && out_ready;
      er    = (!m_dv || efire) && !flush;
      eacc  = in_valid && er;
      ea    = (rs1 != 0 && wb_en && wb_addr == rs1) ? wb_data : m_regs[rs1];
      eb    = (rs2 != 0 && wb_en && wb_addr == rs2) ? wb_data : m_regs[rs2];
      eimm  = ref_imm(m_di);

      checks++;
      if (out_valid !== ev || in_ready !== er) begin
        errors++; $display("FAIL rand_hs[%0d]: v=%b rdy=%b want %b/%b instr=%h", n, out_valid, in_ready, ev, er, m_di);
      end
      if (ev) begin
        checks++;
        if (out_op_a !== ea || out_op_b !== eb) begin
          errors++; $display("FAIL rand_ops[%0d]: a=%h b=%h want %h/%h", n, out_op_a, out_op_b, ea, eb);
        end
        checks++;
        if (out_imm !== eimm || out_b_sel !== ref_bsel(m_di[6:0]) || out_rd !== rd ||
            out_rd_we !== ref_rdwe(m_di) || out_instr !== m_di) begin
          errors++; $display("FAIL rand_dec[%0d]: imm=%h bsel=%b rd=%0d we=%b instr=%h want %h/%b/%0d/%b/%h",
                             n, out_imm, out_b_sel, out_rd, out_rd_we, out_instr,
                             eimm, ref_bsel(m_di[6:0]), rd, ref_rdwe(m_di), m_di);
        end
      end
      cyc();

      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (wb_en) m_pend[wb_addr] = 1'b0;
      if (efire && ref_rdwe(m_di)) m_pend[rd] = 1'b1;
      if (flush) m_dv = 1'b0;
      else if (eacc) begin m_dv = 1'b1; m_di = in_instr; end
      else if (efire) m_dv = 1'b0;
    end
    idle();
  endtask

  task automatic test_xlen64();
    in_valid64 = 1'b1; out_ready64 = 1'b1;
    in_instr64 = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, K_STORE};
    cyc();
    in_instr64 = {20'h80000, 5'd1, K_LUI};
    #1;
    checks++;
    if (out_valid64 !== 1'b1 || imm64 !== 64'hFFFFFFFFFFFFFFFC || b_sel64 !== 1'b1 || rd_we64 !== 1'b0) begin
      errors++; $display("FAIL sw_imm64: v=%b imm=%h bsel=%b we=%b want 1/fffffffffffffffc/1/0",
                         out_valid64, imm64, b_sel64, rd_we64);
    end
    cyc();
    in_valid64 = 1'b0;
    #1;
    checks++;
    if (out_valid64 !== 1'b1 || imm64 !== 64'hFFFFFFFF80000000 || rd64 !== 4'd1 || rd_we64 !== 1'b1) begin
      errors++; $display("FAIL lui_imm64: v=%b imm=%h rd=%0d we=%b want 1/ffffffff80000000/1/1",
                         out_valid64, imm64, rd64, rd_we64);
    end
    cyc();
    out_ready64 = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    idle();
    in_valid64 = 1'b0; in_instr64 = '0; flush64 = 1'b0; wb_en64 = 1'b0;
    wb_addr64 = '0; wb_data64 = '0; out_ready64 = 1'b0;
    test_reset();
    test_issue_raw();
    test_hold();
    test_lui_beq();
    test_flush();
    test_waw_set_wins();
    test_xlen64();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter XLEN, 32, operand/data width (32 or 64); immediates sign-extend to XLEN.
REQ-002 Parameter NREG, 32, architectural register count, power of two, 2..32; AW = clog2(NREG).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  instruction offered by fetch.
REQ-006 in_instr  input  32  RV32I encoding.
REQ-007 in_ready  output  1  decode register can accept this cycle.
REQ-008 flush  input  1  discard held instruction (branch redirect).
REQ-009 wb_en  input  1  writeback strobe.
REQ-010 wb_addr  input  AW  writeback register.
REQ-011 wb_data  input  XLEN  writeback value.
REQ-012 out_valid  output  1  issued operands valid.
REQ-013 out_ready  input  1  execute stage accepts.
REQ-014 out_op_a / out_op_b  output  XLEN  rs1 / rs2 values, bypassed.
REQ-015 out_imm  output  XLEN  decoded immediate; out_b_sel output 1, 1 = execute uses imm for B.
REQ-016 out_rd output AW, out_rd_we output 1, out_instr output 32: destination, write flag, raw instruction.

Function
REQ-017 One-entry decode register D (d_valid, d_instr); fire = out_valid & out_ready; accept = in_valid & in_ready.
REQ-018 in_ready = ~d_valid | fire; on accept D loads in_instr and d_valid=1; on fire without accept d_valid=0.
REQ-019 Latency: instruction accepted at edge N presents out_valid in cycle after edge N at earliest (1 cycle).
REQ-020 Decode from d_instr: rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0], truncated to AW bits.
REQ-021 Immediate by opcode: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL); R-type and unknown give 0.
REQ-022 out_b_sel=1 for OP-IMM, LOAD, STORE, JALR, LUI, AUIPC, JAL; 0 otherwise.
REQ-023 rd_we=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR and rd!=0; else 0; out_rd_we=rd_we.
REQ-024 uses_rs1 for all opcodes except LUI, AUIPC, JAL; uses_rs2 for OP, STORE, BRANCH only.
REQ-025 Register file NREG x XLEN; x0 reads 0, writes to x0 ignored; write on wb_en at edge.
REQ-026 Operand read bypass: if wb_en & wb_addr==rsN & rsN!=0, operand = wb_data, else file value.
REQ-027 Scoreboard: one pending bit per register; bit 0 never set.
REQ-028 Set pending[rd] on fire & rd_we; clear pending[wb_addr] on wb_en; same-register set and clear in one cycle: set wins.
REQ-029 hazard = (uses_rs1 & pend_eff[rs1]) | (uses_rs2 & pend_eff[rs2]) | (rd_we & pending[rd]); pend_eff[r] = pending[r] & ~(wb_en & wb_addr==r).
REQ-030 WAW (rd already pending) stalls even if wb_en targets rd this cycle.
REQ-031 out_valid = d_valid & ~hazard & ~flush; outputs other than out_valid are don't-care when out_valid=0 but must be stable while out_valid=1 and out_ready=0.
REQ-032 flush: d_valid=0 next edge, in_ready=0 that cycle, no fire, scoreboard unchanged; pending writebacks still clear bits.
REQ-033 Unknown opcode issues with rd_we=0, no operand hazards.

Reset
REQ-034 nrst=0 at edge: d_valid=0, all pending bits 0, register file entries 0; outputs then out_valid=0, in_ready=1.
REQ-035 Reset mid-stall discards D; a wb_en in the reset cycle is ignored.

Verification
REQ-036 Reset, write x5=0x11 via wb, issue ADDI x6,x5,3 (out_ready=1) -> out_valid one cycle after accept, op_a=0x11, imm=3, b_sel=1, rd=6, rd_we=1.
REQ-037 Issue ADD x7,x6,x6 right after ADDI x6 -> out_valid=0 until wb_en x6=0x14; in wb cycle out_valid=1, op_a=op_b=0x14.
REQ-038 out_ready=0 for 3 cycles with D valid -> in_ready=0, outputs held stable, pending unchanged; then one fire.
REQ-039 Issue LUI x0,0x12345 -> rd_we=0, no pending set; BEQ x1,x2,-8 -> imm=0xFFFFFFF8, b_sel=0, rd_we=0.
REQ-040 Flush while D holds stalled instruction -> d_valid=0 next cycle, no pending bit set, next instruction accepted normally.
REQ-041 Fire ADDI x3 in same cycle wb_en x3 clears older write -> pending[3]=1 afterwards; XLEN=64/NREG=16 build: SW imm -4 -> 0xFFFFFFFFFFFFFFFC.
